// File: rtl/iter_shifter.sv
// Purpose: multi-cycle shifter (SLL/SRL/SRA/ROR) that moves up to STEP bits per clock.
// Latency: done pulses ceil(eff/STEP)+1 cycles after the start-sampled cycle; out is registered.
// Backpressure: start is only sampled in IDLE; busy stays high through SHIFT and DONE.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       shiftControl,
    input  logic [WIDTH-1:0] shamt,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    // cnt must hold values 0..WIDTH; n must hold values 0..STEP
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(STEP + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_C  = CW'(STEP);

    localparam logic [1:0] MODE_SLL = 2'd0;
    localparam logic [1:0] MODE_SRL = 2'd1;
    localparam logic [1:0] MODE_SRA = 2'd2;
    localparam logic [1:0] MODE_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [1:0]       mode;

    logic [CW-1:0]    eff;
    logic [NW-1:0]    n;
    logic [CW-1:0]    rot_back;
    logic [WIDTH-1:0] shifted;

    // Effective count: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH
    always_comb begin
        eff = '0;
        if (shiftControl == MODE_ROR) begin
            eff = CW'(shamt % WIDTH_V);
        end else if (shamt >= WIDTH_V) begin
            eff = WIDTH_C;
        end else begin
            eff = CW'(shamt);
        end
    end

    // Per-clock step size and the shifted accumulator for the latched mode
    always_comb begin
        n        = '0;
        rot_back = '0;
        shifted  = acc;
        if (cnt > STEP_C) begin
            n = NW'(STEP);
        end else begin
            n = NW'(cnt);
        end
        rot_back = WIDTH_C - CW'(n);
        case (mode)
            MODE_SLL: shifted = acc << n;
            MODE_SRL: shifted = acc >> n;
            MODE_SRA: shifted = WIDTH'($signed(acc) >>> n);
            default:  shifted = (acc >> n) | (acc << rot_back);
        endcase
    end

    // Control FSM with registered busy/done/out; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            acc   <= '0;
            cnt   <= '0;
            mode  <= MODE_SLL;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc  <= data;
                        mode <= shiftControl;
                        cnt  <= eff;
                        busy <= 1'b1;
                        if (eff == '0) begin
                            // nothing to shift: result is the operand itself
                            out   <= data;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - CW'(n);
                    if (cnt <= STEP_C) begin
                        out   <= shifted;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
